// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus a bulk clear of x1..x31.
// Grant (req_ready) is combinational in the request cycle; the write-port outputs follow one posedge later.
// A requester that is not granted simply keeps waiting; clr_req and a running clear hold off all grants.
// Optional build macro: RFARB_WAIT_STAT_EN adds per-requester saturating wait counters (wait_cnt).
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 rf_w_en,
  output logic [AW-1:0]        rf_addr,
  output logic [DW-1:0]        rf_data
`ifdef RFARB_WAIT_STAT_EN
  ,
  output logic [NREQ*16-1:0]   wait_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   rr_ptr_d;
  logic [AW-1:0]   clr_cnt_q;
  logic            wen_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic            busy_q;

  logic [PW-1:0]   winner;
  logic            grant_vld;
  logic            arb_en;
  logic [NREQ-1:0] grant;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  int              idx;

  // Scan from rr_ptr upward (wrapping); the lowest offset with valid set wins.
  always_comb begin
    winner    = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        winner    = PW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  // Winner's payload, next pointer and the one-hot grant (suppressed by reset, clear and clr_req).
  always_comb begin
    win_addr  = req_addr[int'(winner)*AW +: AW];
    win_data  = req_data[int'(winner)*DW +: DW];
    rr_ptr_d  = (int'(winner) == NREQ - 1) ? '0 : winner + PW'(1);
    arb_en    = !rst && (state_q == IDLE) && !clr_req && grant_vld;
    grant     = arb_en ? (NREQ'(1) << winner) : '0;
  end

  assign req_ready = grant;
  assign rf_w_en   = wen_q;
  assign rf_addr   = addr_q;
  assign rf_data   = data_q;
  assign clr_busy  = busy_q;

  // Control FSM: arbitrated writes in IDLE, one zero write per cycle to x1..x31 in CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      clr_cnt_q <= AW'(1);
      wen_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            wen_q   <= 1'b0;
          end else if (grant_vld) begin
            addr_q   <= win_addr;
            data_q   <= win_data;
            // x0 requests are consumed but never reach the register file.
            wen_q    <= (win_addr != '0);
            rr_ptr_q <= rr_ptr_d;
          end else begin
            wen_q <= 1'b0;
          end
        end
        CLEAR: begin
          wen_q  <= 1'b1;
          addr_q <= clr_cnt_q;
          data_q <= '0;
          if (clr_cnt_q == AW'(31)) begin
            clr_cnt_q <= AW'(1);
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + AW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RFARB_WAIT_STAT_EN
  logic [15:0] wcnt_q [NREQ];
  logic [15:0] wcnt_d [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_wait
      // Next count: +1 for every cycle spent valid but not granted, saturating.
      always_comb begin
        wcnt_d[gi] = wcnt_q[gi];
        if (req_valid[gi] && !grant[gi] && (wcnt_q[gi] != 16'hFFFF))
          wcnt_d[gi] = wcnt_q[gi] + 16'd1;
      end

      // Counter register, cleared only by reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) wcnt_q[gi] <= '0;
        else     wcnt_q[gi] <= wcnt_d[gi];
      end

      assign wait_cnt[gi*16 +: 16] = wcnt_q[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_ready;
  logic            clr_req = 1'b0;
  logic            clr_busy;
  logic            rf_w_en;
  logic [AW-1:0]   rf_addr;
  logic [DW-1:0]   rf_data;
`ifdef RFARB_WAIT_STAT_EN
  logic [N*16-1:0] wait_cnt;
`endif

  rf_wb_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .clr_req(clr_req), .clr_busy(clr_busy),
    .rf_w_en(rf_w_en), .rf_addr(rf_addr), .rf_data(rf_data)
`ifdef RFARB_WAIT_STAT_EN
    , .wait_cnt(wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester-side state: a pending write per requester.
  bit          pend  [N];
  logic [4:0]  paddr [N];
  logic [31:0] pdata [N];

  // Reference model: pointer, remaining clear position (0 = not clearing), expected port values.
  int          m_rr  = 0;
  int          m_clr = 0;
  logic        m_wen = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] mreg [32];
  logic [31:0] rf   [32];
  int          mwait [N];
  logic [N-1:0] last_er;

  // Register file seen by the DUT, and the one predicted by the model; both commit on negedge.
  always @(negedge clk) begin
    if (rf_w_en && rf_addr != 0) rf[rf_addr] = rf_data;
    if (m_wen && m_addr != 0) mreg[m_addr] = m_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = pend[i];
      req_addr[i*AW +: AW]    = paddr[i];
      req_data[i*DW +: DW]    = pdata[i];
    end
  endtask

  task automatic req(input int i, input logic [4:0] a, input logic [31:0] d);
    pend[i] = 1'b1; paddr[i] = a; pdata[i] = d;
    drive();
  endtask

  // One clock: called at posedge+1 with inputs set; predicts, checks grant, then checks outputs.
  task automatic cycle();
    logic [N-1:0] er;
    logic nw; logic [4:0] na; logic [31:0] nd;
    int nclr, nrr;
    er = '0; nw = 1'b0; na = m_addr; nd = m_data; nclr = m_clr; nrr = m_rr;
    if (m_clr != 0) begin
      nw = 1'b1; na = 5'(m_clr); nd = '0;
      nclr = (m_clr == 31) ? 0 : m_clr + 1;
    end else if (clr_req) begin
      nclr = 1;
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (er == '0 && pend[j]) begin
          er[j] = 1'b1; na = paddr[j]; nd = pdata[j]; nw = (paddr[j] != 0);
          nrr = (j + 1) % N;
        end
      end
    end
    for (int i = 0; i < N; i++) if (pend[i] && !er[i] && mwait[i] < 65535) mwait[i]++;
    #3;
    chk("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk); #1;
    m_wen = nw; m_addr = na; m_data = nd; m_clr = nclr; m_rr = nrr;
    last_er = er;
    for (int i = 0; i < N; i++) if (er[i]) pend[i] = 1'b0;
    drive();
    chk("rf_w_en",  64'(rf_w_en),  64'(m_wen));
    chk("rf_addr",  64'(rf_addr),  64'(m_addr));
    chk("rf_data",  64'(rf_data),  64'(m_data));
    chk("clr_busy", 64'(clr_busy), 64'(m_clr != 0));
  endtask

  task automatic model_reset();
    m_rr = 0; m_clr = 0; m_wen = 1'b0; m_addr = '0; m_data = '0;
    for (int i = 0; i < N; i++) mwait[i] = 0;
  endtask

  int busy_cycles;

  initial begin
    for (int i = 0; i < 32; i++) begin mreg[i] = '0; rf[i] = '0; end
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; paddr[i] = '0; pdata[i] = '0; mwait[i] = 0; end
    last_er = '0;

    // Reset: ready forced low even with every requester valid.
    req(0, 5'd3, 32'h1); req(1, 5'd4, 32'h2); req(2, 5'd5, 32'h3);
    #12;
    chk("rst_ready",  64'(req_ready), 64'd0);
    chk("rst_w_en",   64'(rf_w_en),   64'd0);
    chk("rst_addr",   64'(rf_addr),   64'd0);
    chk("rst_data",   64'(rf_data),   64'd0);
    chk("rst_busy",   64'(clr_busy),  64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Round-robin: all three valid continuously from rr_ptr=0 -> 0,1,2,0,1,2.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) req(i, 5'(10 + c), 32'(c * 16 + i));
      cycle();
      chk("rr_order", 64'(last_er), 64'(3'b001 << (c % 3)));
      chk("rr_w_en",  64'(rf_w_en), 64'd1);
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    cycle();

    // Single request from requester 1.
    req(1, 5'd5, 32'hDEADBEEF);
    cycle();
    chk("single_ready", 64'(last_er), 64'(3'b010));
    chk("single_addr",  64'(rf_addr), 64'd5);
    chk("single_data",  64'(rf_data), 64'hDEADBEEF);
    cycle();

    // x0 write: handshaken, no register-file write.
    req(0, 5'd0, 32'h1);
    cycle();
    chk("x0_ready", 64'(last_er), 64'(3'b001));
    chk("x0_w_en",  64'(rf_w_en), 64'd0);

    // Clear with x7 preloaded and requester 1 waiting.
    req(2, 5'd7, 32'h55);
    cycle();
    cycle();
    chk("x7_pre", 64'(rf[7]), 64'h55);
    req(1, 5'd9, 32'hCAFE0001);
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 31; c++) begin
      if (clr_busy) busy_cycles++;
      if (c == 10) clr_req = 1'b1;   // ignored while clearing
      cycle();
      clr_req = 1'b0;
      chk("clr_addr", 64'(rf_addr), 64'(c + 1));
    end
    chk("clr_busy_len", 64'(busy_cycles), 64'd31);
    #3;
    chk("clr_then_req1", 64'(req_ready), 64'(3'b010));
    cycle();
    cycle();
    chk("x7_cleared", 64'(rf[7]), 64'd0);

    // Randomised traffic with occasional clear pulses and withdrawals.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] && $urandom_range(7) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(2) == 0) begin
          paddr[i] = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom);
          pdata[i] = $urandom;
          pend[i]  = 1'b1;
        end
      end
      clr_req = ($urandom_range(59) == 0);
      drive();
      cycle();
      clr_req = 1'b0;
    end
    while (m_clr != 0) cycle();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    cycle();

`ifdef RFARB_WAIT_STAT_EN
    for (int i = 0; i < N; i++)
      chk("wait_cnt", 64'(wait_cnt[i*16 +: 16]), 64'(mwait[i]));
`endif

    // Preload x1..x31, then reset in the middle of a clear.
    for (int a = 1; a < 32; a++) begin
      req(0, 5'(a), 32'h1000 + 32'(a));
      cycle();
    end
    cycle();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int g = 0; g < 40 && !(m_wen && m_addr == 12); g++) cycle();
    chk("midclr_at12", 64'(rf_addr), 64'd12);
    rst = 1'b1;
    m_wen = 1'b0;
    #1;
    chk("midrst_w_en", 64'(rf_w_en),  64'd0);
    chk("midrst_addr", 64'(rf_addr),  64'd0);
    chk("midrst_data", 64'(rf_data),  64'd0);
    chk("midrst_busy", 64'(clr_busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int a = 13; a < 32; a++) chk("untouched", 64'(rf[a]), 64'h1000 + 64'(a));
    // After reset the clear counter restarts at 1 and the pointer at 0.
    req(1, 5'd20, 32'h77); req(2, 5'd21, 32'h88);
    cycle();
    chk("post_rst_rr", 64'(last_er), 64'(3'b010));
    cycle();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    cycle();
    chk("post_rst_clr1", 64'(rf_addr), 64'd1);
    while (m_clr != 0) cycle();
    cycle();

    for (int a = 1; a < 32; a++) chk("regfile", 64'(rf[a]), 64'(mreg[a]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
